// File: rtl/mem_pkg.sv
// Shared types, byte-enable constants and load-alignment helpers for mem_stage_nlane.
// Byte order is big-endian: byte offset 0 is bits [31:24].
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LB   = 4'd2,
        OP_LBU  = 4'd3,
        OP_LH   = 4'd4,
        OP_LHU  = 4'd5,
        OP_LWL  = 4'd6,
        OP_LWR  = 4'd7,
        OP_SW   = 4'd8,
        OP_SB   = 4'd9,
        OP_SH   = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_B0   = 4'b1000;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LWR);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SH);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] align_load(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata, input logic [31:0] rt);
        logic [4:0]  ls;
        logic [4:0]  rs;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        ls = {off, 3'b000};
        rs = {~off, 3'b000};
        b  = rdata[rs +: 8];
        h  = off[1] ? rdata[15:0] : rdata[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = off[0] ? rt : {{16{h[15]}}, h};
            OP_LHU:  r = off[0] ? rt : {16'h0, h};
            // LWL fills rt from the top down, LWR from the bottom up
            OP_LWL:  r = (rdata << ls) | (rt & ~(32'hFFFF_FFFF << ls));
            OP_LWR:  r = (rdata >> rs) | (rt & ~(32'hFFFF_FFFF >> rs));
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_nlane_align.sv
// Combinational load-data alignment for the lane currently on the memory port.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] data
);

    assign data = align_load(op, off, rdata, rt);

endmodule

// File: rtl/mem_stage_nlane.sv
// N-lane MEM stage: serialises bundle loads/stores onto one req/ack port and registers MEM/WB.
// Optional MEM_SUBWORD_STORE_EN: SB/SH drive byte enables; otherwise every store is a full word.
module mem_stage_nlane
    import mem_pkg::*;
#(
    parameter int NLANES = 2,
    parameter int DW     = 32,
    parameter int RW     = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NLANES*4-1:0]  ex_mem_op,
    input  logic [NLANES*DW-1:0] ex_alu_result,
    input  logic [NLANES*DW-1:0] ex_rt_data,
    input  logic [NLANES*RW-1:0] ex_rt_reg,
    input  logic [NLANES*RW-1:0] ex_wreg,
    input  logic [NLANES-1:0]    ex_wb_en,
    input  logic [NLANES*DW-1:0] wb_data,
    input  logic [NLANES*RW-1:0] wb_wreg,
    input  logic [NLANES-1:0]    wb_wb_en,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [DW-1:0]        dm_addr,
    output logic [DW-1:0]        dm_wdata,
    output logic [3:0]           dm_be,
    input  logic                 dm_ack,
    input  logic [DW-1:0]        dm_rdata,
    output logic                 stall,
    output logic                 align_err,
    output logic [NLANES*DW-1:0] id_fwd_data,
    output logic [NLANES*DW-1:0] pr_data,
    output logic [NLANES*RW-1:0] pr_wreg,
    output logic [NLANES-1:0]    pr_wb_en
);

    localparam int LIW = (NLANES > 1) ? $clog2(NLANES) : 1;

    state_e              state, state_nxt;
    logic [NLANES-1:0]   pend_p1, mem_mask;
    logic [3:0]          op_p1   [NLANES];
    logic [DW-1:0]       addr_p1 [NLANES];
    logic [DW-1:0]       rt_p1   [NLANES];
    logic [DW-1:0]       ld_p1   [NLANES];
    logic [DW-1:0]       rt_fwd  [NLANES];
    logic [LIW-1:0]      cur;
    logic [3:0]          cur_op;
    logic [DW-1:0]       cur_addr, cur_rt, ld_aligned, st_data;
    logic [3:0]          st_be;
    logic                last_ack;
    logic [NLANES*DW-1:0] commit_data;

    always_comb begin
        mem_mask = '0;
        for (int i = 0; i < NLANES; i++)
            mem_mask[i] = is_load(ex_mem_op[i*4 +: 4]) || is_store(ex_mem_op[i*4 +: 4]);
    end

    // Highest-index matching WB lane wins; r0 is never forwarded
    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            rt_fwd[i] = ex_rt_data[i*DW +: DW];
            for (int j = 0; j < NLANES; j++)
                if (wb_wb_en[j] && (wb_wreg[j*RW +: RW] == ex_rt_reg[i*RW +: RW]) &&
                    (ex_rt_reg[i*RW +: RW] != '0))
                    rt_fwd[i] = wb_data[j*DW +: DW];
        end
    end

    always_comb begin
        cur = '0;
        for (int i = NLANES - 1; i >= 0; i--)
            if (pend_p1[i]) cur = LIW'(i);
    end

    assign cur_op   = op_p1[cur];
    assign cur_addr = addr_p1[cur];
    assign cur_rt   = rt_p1[cur];
    assign last_ack = dm_ack && ((pend_p1 & ~(NLANES'(1) << cur)) == '0);

    mem_load_align u_align (
        .op    (cur_op),
        .off   (cur_addr[1:0]),
        .rdata (dm_rdata),
        .rt    (cur_rt),
        .data  (ld_aligned)
    );

    always_comb begin
        st_be   = BE_WORD;
        st_data = cur_rt;
`ifdef MEM_SUBWORD_STORE_EN
        case (cur_op)
            OP_SB: begin
                st_be   = BE_B0 >> cur_addr[1:0];
                st_data = {4{cur_rt[7:0]}};
            end
            OP_SH: begin
                st_be   = cur_addr[1] ? BE_LO : BE_HI;
                st_data = {2{cur_rt[15:0]}};
            end
            default: ;
        endcase
`endif
    end

    assign dm_req   = (state == S_ACCESS);
    assign dm_we    = dm_req && is_store(cur_op);
    assign dm_addr  = dm_req ? {cur_addr[DW-1:2], 2'b00} : '0;
    assign dm_wdata = dm_we ? st_data : '0;
    assign dm_be    = dm_req ? st_be : '0;
    assign stall    = !RESET && (((state == S_IDLE) && (|mem_mask)) || (state == S_ACCESS));

    always_comb begin
        for (int i = 0; i < NLANES; i++)
            commit_data[i*DW +: DW] = is_load(op_p1[i]) ? ld_p1[i] : ex_alu_result[i*DW +: DW];
        id_fwd_data = RESET ? '0 : ((state == S_COMMIT) ? commit_data : ex_alu_result);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|mem_mask) state_nxt = S_ACCESS;
            S_ACCESS: if (last_ack)  state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // MEM/WB boundary and FSM control
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            pend_p1   <= '0;
            align_err <= 1'b0;
            pr_data   <= '0;
            pr_wreg   <= '0;
            pr_wb_en  <= '0;
        end else begin
            state     <= state_nxt;
            align_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|mem_mask) begin
                        pend_p1  <= mem_mask;
                        pr_wb_en <= '0;
                    end else begin
                        pr_data  <= ex_alu_result;
                        pr_wreg  <= ex_wreg;
                        pr_wb_en <= ex_wb_en;
                    end
                end
                S_ACCESS: begin
                    pr_wb_en <= '0;
                    if (dm_ack) begin
                        pend_p1[cur] <= 1'b0;
                        align_err    <= misaligned(cur_op, cur_addr[1:0]);
                    end
                end
                S_COMMIT: begin
                    pr_data  <= commit_data;
                    pr_wreg  <= ex_wreg;
                    pr_wb_en <= ex_wb_en;
                end
                default: pr_wb_en <= '0;
            endcase
        end
    end

    // Bundle operand capture (data path, no reset)
    always_ff @(posedge CLK) begin
        if ((state == S_IDLE) && (|mem_mask)) begin
            for (int i = 0; i < NLANES; i++) begin
                op_p1[i]   <= ex_mem_op[i*4 +: 4];
                addr_p1[i] <= ex_alu_result[i*DW +: DW];
                rt_p1[i]   <= rt_fwd[i];
            end
        end
        if ((state == S_ACCESS) && dm_ack)
            ld_p1[cur] <= ld_aligned;
    end

endmodule

// File: tb/tb_mem_stage_nlane.sv
// Directed self-checking bench for mem_stage_nlane (2 lanes, default build).
module tb_mem_stage_nlane;

    localparam int NL = 2;
    localparam int DW = 32;
    localparam int RW = 5;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NL*4-1:0] ex_mem_op;
    logic [NL*DW-1:0] ex_alu_result, ex_rt_data, wb_data;
    logic [NL*RW-1:0] ex_rt_reg, ex_wreg, wb_wreg;
    logic [NL-1:0]   ex_wb_en, wb_wb_en;
    logic            dm_req, dm_we, dm_ack, stall, align_err;
    logic [DW-1:0]   dm_addr, dm_wdata, dm_rdata;
    logic [3:0]      dm_be;
    logic [NL*DW-1:0] id_fwd_data, pr_data;
    logic [NL*RW-1:0] pr_wreg;
    logic [NL-1:0]   pr_wb_en;

    mem_stage_nlane #(.NLANES(NL), .DW(DW), .RW(RW)) dut (
        .CLK(CLK), .RESET(RESET),
        .ex_mem_op(ex_mem_op), .ex_alu_result(ex_alu_result), .ex_rt_data(ex_rt_data),
        .ex_rt_reg(ex_rt_reg), .ex_wreg(ex_wreg), .ex_wb_en(ex_wb_en),
        .wb_data(wb_data), .wb_wreg(wb_wreg), .wb_wb_en(wb_wb_en),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .align_err(align_err), .id_fwd_data(id_fwd_data),
        .pr_data(pr_data), .pr_wreg(pr_wreg), .pr_wb_en(pr_wb_en)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wdata [2];
    logic        rq_we [2];
    logic [3:0]  rq_be [2];
    int          nreq;
    logic        err_seen;
    int          ns;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_bundle();
        ex_mem_op = '0; ex_alu_result = '0; ex_rt_data = '0; ex_rt_reg = '0;
        ex_wreg = '0; ex_wb_en = '0; wb_data = '0; wb_wreg = '0; wb_wb_en = '0;
    endtask

    task automatic set_lane(input int l, input logic [3:0] op, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [4:0] rtreg,
                            input logic [4:0] wreg, input logic wben);
        ex_mem_op[l*4 +: 4]      = op;
        ex_alu_result[l*DW +: DW] = alu;
        ex_rt_data[l*DW +: DW]   = rt;
        ex_rt_reg[l*RW +: RW]    = rtreg;
        ex_wreg[l*RW +: RW]      = wreg;
        ex_wb_en[l]              = wben;
    endtask

    // Memory responder: acks the n-th request after its latency; counts stall cycles
    task automatic run_bundle(input int lat0, input logic [31:0] rd0, input int lat1,
                              input logic [31:0] rd1, input logic clr_wb, output int nstall);
        int wc;
        int guard;
        int lat;
        wc = 0; guard = 0; nstall = 0; nreq = 0; err_seen = 1'b0;
        #1;
        while (stall && guard < 40) begin
            nstall++;
            if (dm_req && nreq < 2) begin
                wc++;
                lat = (nreq == 0) ? lat0 : lat1;
                if (wc >= lat) begin
                    dm_ack   = 1'b1;
                    dm_rdata = (nreq == 0) ? rd0 : rd1;
                    rq_addr[nreq]  = dm_addr;
                    rq_we[nreq]    = dm_we;
                    rq_wdata[nreq] = dm_wdata;
                    rq_be[nreq]    = dm_be;
                    nreq++;
                    wc = 0;
                end
            end
            step();
            dm_ack = 1'b0;
            dm_rdata = '0;
            if (clr_wb) begin
                wb_wb_en = '0;
                wb_data  = '0;
            end
            err_seen = err_seen | align_err;
            guard++;
        end
        if (guard >= 40) chk("stall_timeout", guard, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
        clear_bundle();
        step(); step();
        RESET = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_pr_wb_en", pr_wb_en, 0);
        chk("rst_pr_data0", pr_data[31:0], 0);
        chk("rst_align_err", align_err, 0);

        // ALU-only bundle
        set_lane(0, 4'd0, 32'h11, 32'h0, 5'd0, 5'd2, 1'b1);
        set_lane(1, 4'd0, 32'h22, 32'h0, 5'd0, 5'd3, 1'b1);
        #1;
        chk("alu_stall", stall, 0);
        chk("alu_req", dm_req, 0);
        step();
        chk("alu_pr0", pr_data[31:0], 32'h11);
        chk("alu_pr1", pr_data[63:32], 32'h22);
        chk("alu_wb_en", pr_wb_en, 2'b11);
        chk("alu_wreg", pr_wreg, 32'h62);

        // LB with sign extension, ack latency 2
        clear_bundle();
        set_lane(0, 4'd2, 32'h101, 32'h0, 5'd0, 5'd4, 1'b1);
        set_lane(1, 4'd0, 32'h44, 32'h0, 5'd0, 5'd6, 1'b1);
        run_bundle(2, 32'h12F45678, 1, 32'h0, 1'b0, ns);
        chk("lb_nstall", ns, 3);
        chk("lb_nreq", nreq, 1);
        chk("lb_addr", rq_addr[0], 32'h100);
        chk("lb_we", rq_we[0], 0);
        chk("lb_bubble", pr_wb_en, 0);
        chk("lb_fwd0", id_fwd_data[31:0], 32'hFFFFFFF4);
        chk("lb_fwd1", id_fwd_data[63:32], 32'h44);
        chk("lb_err", err_seen, 0);
        step();
        chk("lb_pr0", pr_data[31:0], 32'hFFFFFFF4);
        chk("lb_pr1", pr_data[63:32], 32'h44);
        chk("lb_wb_en", pr_wb_en, 2'b11);

        // SW lane0 then LHU lane1
        clear_bundle();
        set_lane(0, 4'd8, 32'h300, 32'hCAFEF00D, 5'd7, 5'd0, 1'b0);
        set_lane(1, 4'd5, 32'h202, 32'h0, 5'd0, 5'd9, 1'b1);
        run_bundle(1, 32'hFFFFFFFF, 1, 32'hAAAA1234, 1'b0, ns);
        chk("swlh_nstall", ns, 3);
        chk("swlh_nreq", nreq, 2);
        chk("swlh_addr0", rq_addr[0], 32'h300);
        chk("swlh_we0", rq_we[0], 1);
        chk("swlh_wdata0", rq_wdata[0], 32'hCAFEF00D);
        chk("swlh_be0", rq_be[0], 4'hF);
        chk("swlh_addr1", rq_addr[1], 32'h200);
        chk("swlh_we1", rq_we[1], 0);
        step();
        chk("swlh_pr0", pr_data[31:0], 32'h300);
        chk("swlh_pr1", pr_data[63:32], 32'h00001234);
        chk("swlh_wb_en", pr_wb_en, 2'b10);

        // WB forwarding: highest lane wins, WB cleared after IDLE sample
        clear_bundle();
        set_lane(0, 4'd8, 32'h400, 32'h0BADF00D, 5'd5, 5'd0, 1'b0);
        wb_wreg = {5'd5, 5'd5}; wb_data = {32'hDEADBEEF, 32'h1}; wb_wb_en = 2'b11;
        run_bundle(2, 32'h0, 1, 32'h0, 1'b1, ns);
        chk("fwd_nstall", ns, 3);
        chk("fwd_wdata", rq_wdata[0], 32'hDEADBEEF);
        step();

        // r0 is never forwarded
        clear_bundle();
        set_lane(0, 4'd8, 32'h404, 32'h55, 5'd0, 5'd0, 1'b0);
        wb_wreg = {5'd0, 5'd0}; wb_data = {32'h99, 32'h0}; wb_wb_en = 2'b10;
        run_bundle(1, 32'h0, 1, 32'h0, 1'b0, ns);
        chk("r0_nstall", ns, 2);
        chk("r0_wdata", rq_wdata[0], 32'h55);
        step();
        chk("r0_pr0", pr_data[31:0], 32'h404);

        // LWL offset 3 and LWR offset 0
        clear_bundle();
        set_lane(0, 4'd6, 32'h3, 32'h11223344, 5'd8, 5'd8, 1'b1);
        set_lane(1, 4'd7, 32'h4, 32'h11223344, 5'd9, 5'd9, 1'b1);
        run_bundle(1, 32'hAABBCCDD, 3, 32'hAABBCCDD, 1'b0, ns);
        chk("lwlr_nstall", ns, 5);
        chk("lwlr_addr0", rq_addr[0], 32'h0);
        chk("lwlr_addr1", rq_addr[1], 32'h4);
        step();
        chk("lwl_pr0", pr_data[31:0], 32'hDD223344);
        chk("lwr_pr1", pr_data[63:32], 32'h112233AA);

        // Misaligned LH keeps rt; misaligned LW returns unshifted data
        clear_bundle();
        set_lane(0, 4'd4, 32'h101, 32'h77, 5'd10, 5'd10, 1'b1);
        set_lane(1, 4'd1, 32'h206, 32'h0, 5'd0, 5'd11, 1'b1);
        run_bundle(1, 32'hFFFF0000, 1, 32'h89ABCDEF, 1'b0, ns);
        chk("mis_nstall", ns, 3);
        chk("mis_err", err_seen, 1);
        step();
        chk("mis_pr0", pr_data[31:0], 32'h77);
        chk("mis_pr1", pr_data[63:32], 32'h89ABCDEF);
        chk("mis_err_clr", align_err, 0);

        // Reset in ACCESS
        clear_bundle();
        set_lane(0, 4'd2, 32'h101, 32'h0, 5'd0, 5'd4, 1'b1);
        #1;
        step();
        chk("racc_req", dm_req, 1);
        chk("racc_stall", stall, 1);
        RESET = 1'b1;
        #1;
        chk("racc_req_drop", dm_req, 0);
        chk("racc_stall_drop", stall, 0);
        chk("racc_wb_en", pr_wb_en, 0);
        chk("racc_addr", dm_addr, 0);
        step();
        RESET = 1'b0;
        clear_bundle();
        set_lane(0, 4'd0, 32'h55, 32'h0, 5'd0, 5'd1, 1'b1);
        set_lane(1, 4'd0, 32'h66, 32'h0, 5'd0, 5'd2, 1'b1);
        #1;
        chk("post_stall", stall, 0);
        step();
        chk("post_pr0", pr_data[31:0], 32'h55);
        chk("post_wb_en", pr_wb_en, 2'b11);
        clear_bundle();
        set_lane(0, 4'd3, 32'h102, 32'h0, 5'd0, 5'd3, 1'b1);
        run_bundle(1, 32'h00008000, 1, 32'h0, 1'b0, ns);
        chk("post_nstall", ns, 2);
        chk("post_addr", rq_addr[0], 32'h100);
        step();
        chk("post_lbu_pr0", pr_data[31:0], 32'h00000080);
        clear_bundle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
